// File: rtl/imem_loader_pkg.sv
// Shared types and constants for the instruction-memory loader.
package imem_loader_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LEN_HI = 3'd1,
    ST_LEN_LO = 3'd2,
    ST_DATA   = 3'd3,
    ST_CSUM   = 3'd4,
    ST_DONE   = 3'd5,
    ST_ERROR  = 3'd6
  } state_t;

  localparam int LEN_BYTES      = 2;
  localparam int BYTES_PER_WORD = 4;

  function automatic logic [7:0] csum_step(input logic [7:0] acc, input logic [7:0] b);
    return acc ^ b;
  endfunction

endpackage

// File: rtl/imem_loader_word_packer.sv
// Byte-to-word assembler: big-endian, emits the finished word with a one-cycle valid pulse.
module imem_word_packer
  import imem_loader_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        clear,
  input  logic        byte_valid,
  input  logic [7:0]  byte_data,
  output logic [1:0]  idx,
  output logic [31:0] word,
  output logic        word_valid
);

  localparam logic [1:0] LAST_IDX = 2'(BYTES_PER_WORD - 1);

  logic [23:0] shift_r;
  logic [1:0]  idx_r;
  logic [31:0] word_r;
  logic        word_valid_r;

  // Keep the three most recent bytes; the fourth completes the word.
  always_ff @(posedge clk) begin
    if (rst) begin
      shift_r      <= 24'd0;
      idx_r        <= 2'd0;
      word_r       <= 32'd0;
      word_valid_r <= 1'b0;
    end else if (clear) begin
      shift_r      <= 24'd0;
      idx_r        <= 2'd0;
      word_valid_r <= 1'b0;
    end else begin
      word_valid_r <= 1'b0;
      if (byte_valid) begin
        shift_r <= {shift_r[15:0], byte_data};
        idx_r   <= idx_r + 2'd1;
        if (idx_r == LAST_IDX) begin
          word_r       <= {shift_r, byte_data};
          word_valid_r <= 1'b1;
        end
      end
    end
  end

  assign idx        = idx_r;
  assign word       = word_r;
  assign word_valid = word_valid_r;

endmodule

// File: rtl/imem_loader.sv
// Instruction-memory loader: parses length/data/checksum stream, writes words, gates core reset.
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int                ADDR_W    = 8,
  parameter logic [ADDR_W-1:0] BASE_ADDR = {ADDR_W{1'b0}}
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [7:0]        in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  output logic              core_rst,
  output logic              busy,
  output logic              done,
  output logic              error
);

  localparam logic [1:0]         LAST_IDX = 2'(BYTES_PER_WORD - 1);
  localparam longint unsigned    CAP      = 64'd1 << ADDR_W;
  localparam int                 LEN_W    = LEN_BYTES * 8;

  state_t state_r, next_state_s;
  logic in_ready_r, busy_r, done_r, error_r, core_rst_r;
  logic in_ready_s, busy_s, done_s, error_s, core_rst_s;

  logic [LEN_W-1:0]  len_r;
  logic [LEN_W-1:0]  word_cnt_r;
  logic [7:0]        csum_r;
  logic [ADDR_W-1:0] addr_r;

  logic        xfer_s, start_ok_s, word_done_s, pk_valid_s;
  logic [1:0]  pk_idx_s;
  logic [31:0] pk_word_s;
  logic [LEN_W-1:0] n_s;

  assign xfer_s      = in_valid & in_ready_r;
  assign start_ok_s  = start & ((state_r == ST_IDLE) | (state_r == ST_DONE) | (state_r == ST_ERROR));
  assign word_done_s = xfer_s & (state_r == ST_DATA) & (pk_idx_s == LAST_IDX);
  assign n_s         = {len_r[15:8], in_data};

  imem_word_packer u_packer (
    .clk        (clk),
    .rst        (rst),
    .clear      (start_ok_s),
    .byte_valid (xfer_s & (state_r == ST_DATA)),
    .byte_data  (in_data),
    .idx        (pk_idx_s),
    .word       (pk_word_s),
    .word_valid (pk_valid_s)
  );

  // State and status flags register; flags follow the state being entered.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r    <= ST_IDLE;
      in_ready_r <= 1'b0;
      busy_r     <= 1'b0;
      done_r     <= 1'b0;
      error_r    <= 1'b0;
      core_rst_r <= 1'b1;
    end else begin
      state_r    <= next_state_s;
      in_ready_r <= in_ready_s;
      busy_r     <= busy_s;
      done_r     <= done_s;
      error_r    <= error_s;
      core_rst_r <= core_rst_s;
    end
  end

  // Next-state decode.
  always_comb begin
    next_state_s = state_r;
    case (state_r)
      ST_IDLE, ST_DONE, ST_ERROR: begin
        if (start) next_state_s = ST_LEN_HI;
        else       next_state_s = state_r;
      end
      ST_LEN_HI: begin
        if (xfer_s) next_state_s = ST_LEN_LO;
        else        next_state_s = state_r;
      end
      ST_LEN_LO: begin
        if (!xfer_s)                    next_state_s = state_r;
        else if ({48'd0, n_s} > CAP)    next_state_s = ST_ERROR;
        else if (n_s == 16'd0)          next_state_s = ST_CSUM;
        else                            next_state_s = ST_DATA;
      end
      ST_DATA: begin
        if (word_done_s && (word_cnt_r == len_r - 16'd1)) next_state_s = ST_CSUM;
        else                                              next_state_s = state_r;
      end
      ST_CSUM: begin
        if (!xfer_s)                 next_state_s = state_r;
        else if (in_data == csum_r)  next_state_s = ST_DONE;
        else                         next_state_s = ST_ERROR;
      end
      default: next_state_s = ST_IDLE;
    endcase
  end

  // Status decode of the state being entered.
  always_comb begin
    in_ready_s = 1'b0;
    busy_s     = 1'b0;
    done_s     = 1'b0;
    error_s    = 1'b0;
    core_rst_s = 1'b1;
    case (next_state_s)
      ST_LEN_HI, ST_LEN_LO, ST_DATA, ST_CSUM: begin
        in_ready_s = 1'b1;
        busy_s     = 1'b1;
      end
      ST_DONE: begin
        done_s     = 1'b1;
        core_rst_s = 1'b0;
      end
      ST_ERROR: error_s = 1'b1;
      default:  in_ready_s = 1'b0;
    endcase
  end

  // Length, word count, checksum and write address.
  always_ff @(posedge clk) begin
    if (rst || start_ok_s) begin
      len_r      <= 16'd0;
      word_cnt_r <= 16'd0;
      csum_r     <= 8'd0;
      addr_r     <= BASE_ADDR;
    end else begin
      if (xfer_s) begin
        case (state_r)
          ST_LEN_HI: len_r[15:8] <= in_data;
          ST_LEN_LO: len_r[7:0]  <= in_data;
          ST_DATA:   csum_r      <= csum_step(csum_r, in_data);
          default:   csum_r      <= csum_r;
        endcase
      end
      if (word_done_s) word_cnt_r <= word_cnt_r + 16'd1;
      if (pk_valid_s)  addr_r     <= addr_r + {{(ADDR_W-1){1'b0}}, 1'b1};
    end
  end

  assign in_ready   = in_ready_r;
  assign busy       = busy_r;
  assign done       = done_r;
  assign error      = error_r;
  assign core_rst   = core_rst_r;
  assign imem_we    = pk_valid_s;
  assign imem_wdata = pk_word_s;
  assign imem_addr  = addr_r;

endmodule
